arp_decode: RTL

Receive-side counterpart of the ARP reply encoder. It parses the 28-byte ARP payload, MSB first, from the Ethernet RX path after upstream ethertype 0x0806 filtering. It validates the fixed header fields and the target addresses. For each ARP packet addressed to this device, it presents the sender's hardware and protocol addresses plus the opcode to the ARP responder/cache. Nibble-to-byte assembly for 100M mode is done upstream; this block is byte-wide only.

---
 rtl/arp_decode.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/arp_decode.sv
// Receive-side ARP payload parser: validates the 28-byte header/targets and presents
// sender addresses and opcode of accepted packets, pulsing drop for rejected ones.
module arp_decode #(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter logic [31:0] IP_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    output logic        ovalid,
    output logic        oper_reply,
    output logic [47:0] sha,
    output logic [31:0] spa,
    output logic        drop
);
    typedef enum logic [1:0] {StIdle, StParse, StDrain} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        bad_q, bad_d;
    logic        reply_cap_q, reply_cap_d;
    logic [47:0] sha_cap_q, sha_cap_d;
    logic [31:0] spa_cap_q, spa_cap_d;
    logic        ovalid_d, drop_d, oper_reply_d;
    logic [47:0] sha_d;
    logic [31:0] spa_d;
    logic        byte_bad;
    logic [4:0]  tha_idx, tpa_idx;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;

    // Shift the expected address so the byte for the current index sits in the top lane.
    assign tha_idx = cnt_q - 5'd18;
    assign tpa_idx = cnt_q - 5'd24;
    assign mac_sh  = MAC_ADDR << {tha_idx, 3'b000};
    assign ip_sh   = IP_ADDR << {tpa_idx, 3'b000};

    always_comb begin
        byte_bad = 1'b0;
        case (cnt_q)
            5'd0, 5'd3, 5'd6: byte_bad = (din != 8'h00);
            5'd1:             byte_bad = (din != 8'h01);
            5'd2:             byte_bad = (din != 8'h08);
            5'd4:             byte_bad = (din != 8'h06);
            5'd5:             byte_bad = (din != 8'h04);
            5'd7:             byte_bad = (din != 8'h01) && (din != 8'h02);
            5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23:
                byte_bad = reply_cap_q && (din != mac_sh[47:40]);
            5'd24, 5'd25, 5'd26, 5'd27:
                byte_bad = (din != ip_sh[31:24]);
            default:          byte_bad = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bad_d        = bad_q;
        reply_cap_d  = reply_cap_q;
        sha_cap_d    = sha_cap_q;
        spa_cap_d    = spa_cap_q;
        ovalid_d     = 1'b0;
        drop_d       = 1'b0;
        oper_reply_d = oper_reply;
        sha_d        = sha;
        spa_d        = spa;
        unique case (state_q)
            StIdle, StParse: begin
                if (en) begin
                    if (cnt_q == 5'd7) reply_cap_d = (din == 8'h02);
                    if (cnt_q >= 5'd8 && cnt_q <= 5'd13) sha_cap_d = {sha_cap_q[39:0], din};
                    if (cnt_q >= 5'd14 && cnt_q <= 5'd17) spa_cap_d = {spa_cap_q[23:0], din};
                    if (cnt_q == 5'd27) begin
                        if (bad_q || byte_bad) begin
                            drop_d = 1'b1;
                        end else begin
                            ovalid_d     = 1'b1;
                            sha_d        = sha_cap_q;
                            spa_d        = spa_cap_q;
                            oper_reply_d = reply_cap_q;
                        end
                        state_d = StDrain;
                        cnt_d   = 5'd28;
                        bad_d   = 1'b0;
                    end else begin
                        state_d = StParse;
                        cnt_d   = cnt_q + 5'd1;
                        bad_d   = bad_q | byte_bad;
                    end
                end else if (state_q == StParse) begin
                    // Truncated payload.
                    drop_d  = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                    bad_d   = 1'b0;
                end
            end
            StDrain: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
                bad_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            bad_q       <= 1'b0;
            reply_cap_q <= 1'b0;
            sha_cap_q   <= 48'h0;
            spa_cap_q   <= 32'h0;
            ovalid      <= 1'b0;
            drop        <= 1'b0;
            oper_reply  <= 1'b0;
            sha         <= 48'h0;
            spa         <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            reply_cap_q <= reply_cap_d;
            sha_cap_q   <= sha_cap_d;
            spa_cap_q   <= spa_cap_d;
            ovalid      <= ovalid_d;
            drop        <= drop_d;
            oper_reply  <= oper_reply_d;
            sha         <= sha_d;
            spa         <= spa_d;
        end
    end

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= 5'd28);
    a_ovalid_src: assert property (@(posedge clk) disable iff (rst)
        ovalid |-> $past(state_q == StParse && cnt_q == 5'd27));
    a_excl: assert property (@(posedge clk) disable iff (rst) !(ovalid && drop));
`endif
endmodule
